// File: rtl/grp_pkg.sv
// Shared types and helpers for the GRP round controller.
package grp_pkg;

    localparam int DW  = 32;
    localparam int RW  = 3;
    localparam int ROT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Left-rotate a control word by n bit positions (n taken modulo DW).
    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] x, input int unsigned n);
        logic [2*DW-1:0] t;
        t = {x, x} << (n % DW);
        return t[2*DW-1:DW];
    endfunction

endpackage

// File: rtl/grp_round_ctrl_perm.sv
// Combinational GRP permutation: bits selected by Y pack toward the MSB in
// order, unselected bits pack from the LSB upward (so that group is reversed).
module grp_perm_comb (
    input  logic [31:0] X,
    input  logic [31:0] Y,
    output logic [31:0] P
);

    logic [4:0] hi_pos;
    logic [4:0] lo_pos;

    // Single MSB-first scan with two fill pointers.
    always_comb begin
        P      = '0;
        hi_pos = 5'd31;
        lo_pos = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (Y[i]) begin
                P[hi_pos] = X[i];
                hi_pos    = hi_pos - 5'd1;
            end else begin
                P[lo_pos] = X[i];
                lo_pos    = lo_pos + 5'd1;
            end
        end
    end

endmodule

// File: rtl/grp_round_ctrl.sv
// Multi-round GRP controller: accepts a request, runs one permutation per
// clock with a rotating control word, then holds the result until taken.
//
// state | meaning
// IDLE  | ready for a request
// RUN   | one permutation round per clock, rem_q rounds left
// DONE  | result presented on out_data until out_ready
import grp_pkg::*;

module grp_round_ctrl #(
    parameter int DW  = grp_pkg::DW,
    parameter int RW  = grp_pkg::RW,
    parameter int ROT = grp_pkg::ROT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_data,
    input  logic [31:0]   in_key,
    input  logic [RW-1:0] in_rounds,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_data,
    output logic          busy,
    output logic [RW-1:0] round_idx
);

    state_t        state_q,     state_d;
    logic [31:0]   data_q,      data_d;
    logic [31:0]   ctrl_q,      ctrl_d;
    logic [RW-1:0] rem_q,       rem_d;
    logic [RW-1:0] round_idx_q, round_idx_d;
    logic [31:0]   out_data_q,  out_data_d;
    logic [31:0]   perm_out;

    grp_perm_comb u_perm (
        .X (data_q),
        .Y (ctrl_q),
        .P (perm_out)
    );

    // Next-state and datapath updates; everything holds unless a state acts.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        ctrl_d      = ctrl_q;
        rem_d       = rem_q;
        round_idx_d = round_idx_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d      = in_data;
                    ctrl_d      = in_key;
                    rem_d       = in_rounds;
                    round_idx_d = '0;
                    if (in_rounds != '0) begin
                        state_d = RUN;
                    end else begin
                        // zero rounds: the word passes straight through
                        state_d    = DONE;
                        out_data_d = in_data;
                    end
                end
            end
            RUN: begin
                data_d      = perm_out;
                ctrl_d      = rotl(ctrl_q, ROT);
                round_idx_d = round_idx_q + RW'(1);
                rem_d       = rem_q - RW'(1);
                if (rem_q == RW'(1)) begin
                    out_data_d = perm_out;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            ctrl_q      <= '0;
            rem_q       <= '0;
            round_idx_q <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            rem_q       <= rem_d;
            round_idx_q <= round_idx_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign round_idx = round_idx_q;

endmodule

// File: tb/tb_grp_round_ctrl.sv
// Scoreboard bench for grp_round_ctrl: the driver pushes expected results at
// accept time, an independent monitor pops and compares on each output.
module tb_grp_round_ctrl;
    import grp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] in_key;
    logic [2:0]  in_rounds;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic [2:0]  round_idx;

    grp_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_rounds (in_rounds),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .round_idx (round_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          rounds;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   lat_done = 1'b0;
    int   last_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model, formulated as two compress operations.
    function automatic logic [31:0] ref_perm(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] s = '0;
        logic [31:0] z = '0;
        int          nh = 0;
        for (int i = 31; i >= 0; i--) begin
            if (y[i]) begin
                s = {s[30:0], x[i]};
                nh++;
            end
        end
        for (int i = 0; i < 32; i++) begin
            if (!y[i]) z = {z[30:0], x[i]};
        end
        if (nh == 0) return z;
        return (s << (32 - nh)) | z;
    endfunction

    function automatic logic [31:0] ref_rotl(input logic [31:0] x);
        return (x << 8) | (x >> 24);
    endfunction

    function automatic logic [31:0] ref_run(input logic [31:0] d, input logic [31:0] k, input int r);
        logic [31:0] dd = d;
        logic [31:0] kk = k;
        for (int j = 0; j < r; j++) begin
            dd = ref_perm(dd, kk);
            kk = ref_rotl(kk);
        end
        return dd;
    endfunction

    // Monitor: latency on first sight of out_valid, data on the handshake.
    // out_valid first visible after edge acc+rounds (sampled at edge acc+rounds+1).
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=%h required=none", out_data);
            end else begin
                if (!lat_done) begin
                    chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].rounds));
                    lat_done = 1'b1;
                end
                if (out_ready) begin
                    chk("out_data", out_data, sb[0].data);
                    void'(sb.pop_front());
                    lat_done = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] d, input logic [31:0] k, input logic [2:0] r,
                         input logic [31:0] exp_data);
        int n = 0;
        in_data   = d;
        in_key    = k;
        in_rounds = r;
        in_valid  = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=no_accept required=accept");
                in_valid = 1'b0;
                return;
            end
        end
        last_acc = cyc + 1;
        sb.push_back('{exp_data, int'(r), cyc + 1});
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = $urandom;
        in_key    = $urandom;
        in_rounds = 3'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] k;
        int          prev;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_key    = '0;
        in_rounds = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_round_idx", 32'(round_idx), 32'd0);
        @(posedge clk);
        #1;

        // single round, mixed key
        issue(32'h12345678, 32'hFFFF0000, 3'd1, 32'h12341E6A);
        drain();

        // all-zero key reverses; two rounds reverse back
        issue(32'h00000001, 32'h00000000, 3'd1, 32'h80000000);
        drain();
        issue(32'h00000001, 32'h00000000, 3'd2, 32'h00000001);
        drain();

        // max rounds with identity key; round_idx walks 0..6
        issue(32'hDEADBEEF, 32'hFFFFFFFF, 3'd7, 32'hDEADBEEF);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("round_idx", 32'(round_idx), 32'(i));
            chk("busy_run",  32'(busy),      32'd1);
        end
        drain();

        // zero rounds pass-through, consumer stalls for 5 clocks
        out_ready = 1'b0;
        issue(32'hCAFEF00D, 32'h13579BDF, 3'd0, 32'hCAFEF00D);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_out_data",  out_data,       32'hCAFEF00D);
            chk("hold_in_ready",  32'(in_ready),  32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_busy",      32'(busy),      32'd0);
        chk("release_in_ready",  32'(in_ready),  32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);

        // asynchronous reset during RUN of a 5-round request
        issue(32'hA5A5A5A5, 32'h3C3C3C3C, 3'd5, ref_run(32'hA5A5A5A5, 32'h3C3C3C3C, 5));
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_in_ready",  32'(in_ready),  32'd1);
        chk("abort_out_data",  out_data,       32'd0);
        sb.delete();
        lat_done = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        issue(32'h0F0F1234, 32'h89ABCDEF, 3'd5, ref_run(32'h0F0F1234, 32'h89ABCDEF, 5));
        drain();

        // back-to-back 3-round requests with junk on the inputs during RUN
        prev = 0;
        for (int j = 0; j < 3; j++) begin
            d = $urandom;
            k = $urandom;
            issue(d, k, 3'd3, ref_run(d, k, 3));
            if (j > 0) chk("issue_spacing", 32'(last_acc - prev), 32'd5);
            prev      = last_acc;
            in_valid  = 1'b1;
            in_data   = $urandom;
            in_key    = $urandom;
            in_rounds = 3'($urandom);
            @(posedge clk);
            #1;
            in_data   = $urandom;
            in_key    = $urandom;
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
